// File: rtl/rvh_l2_ewrq_rx.sv
// L2-side receiver for L1D evictions: takes AW requests plus the write burst
// of dirty lines and queues one whole-line record per eviction.
module rvh_l2_ewrq_rx #(
  parameter int unsigned OUT_DEPTH   = 2,
  parameter int unsigned LINE_ADDR_W = 14,
  parameter int unsigned BEAT_W      = 64,
  parameter int unsigned BEATS       = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        l2_req_if_awvalid,
  output logic                        l2_req_if_awready,
  input  logic [LINE_ADDR_W+1:0]      l2_req_if_aw,
  input  logic                        l2_req_if_wvalid,
  output logic                        l2_req_if_wready,
  input  logic [BEAT_W-1:0]           l2_req_if_w,
  output logic                        evict_vld_o,
  input  logic                        evict_rdy_i,
  output logic [LINE_ADDR_W-1:0]      evict_line_addr_o,
  output logic [1:0]                  evict_mesi_o,
  output logic                        evict_dirty_o,
  output logic [BEATS*BEAT_W-1:0]     evict_data_o,
  output logic                        busy_o,
  output logic                        proto_err_o
);

  localparam int unsigned LINE_W     = BEATS * BEAT_W;
  localparam int unsigned BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PTR_W      = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CNT_W      = $clog2(OUT_DEPTH + 1);

  typedef enum logic {IDLE = 1'b0, DATA = 1'b1} state_e;

  typedef struct packed {
    logic [LINE_ADDR_W-1:0] addr;
    logic [1:0]             mesi;
    logic                   dirty;
    logic [LINE_W-1:0]      data;
  } rec_t;

  state_e                  state_q, state_d;
  logic [BEAT_CNT_W-1:0]   beat_q, beat_d;
  logic [LINE_W-1:0]       line_q, line_d;
  logic [LINE_ADDR_W-1:0]  addr_q, addr_d;
  logic [1:0]              mesi_q, mesi_d;
  logic                    proto_err_q, proto_err_d;
  logic                    ready_q;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [CNT_W:0]          resv;
  rec_t                    mem_q [OUT_DEPTH];
  rec_t                    push_rec, head_rec;
  logic                    push, pop, aw_hs;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every queue slot that could be pushed is already counted at AW acceptance,
  // so the data-phase push below never needs to check for space.
  assign resv              = {1'b0, count_q} + (CNT_W+1)'(state_q == DATA);
  assign l2_req_if_awready = ready_q && (state_q == IDLE) && (resv < (CNT_W+1)'(OUT_DEPTH));
  assign l2_req_if_wready  = (state_q == DATA);
  assign aw_hs             = l2_req_if_awvalid && l2_req_if_awready;
  assign evict_vld_o       = (count_q != '0);
  assign pop               = evict_vld_o && evict_rdy_i;
  assign busy_o            = (state_q == DATA) || evict_vld_o;
  assign proto_err_o       = proto_err_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    beat_d      = beat_q;
    line_d      = line_q;
    addr_d      = addr_q;
    mesi_d      = mesi_q;
    proto_err_d = proto_err_q;
    push        = 1'b0;
    push_rec    = '0;
    unique case (state_q)
      IDLE: begin
        if (l2_req_if_wvalid) proto_err_d = 1'b1;
        if (aw_hs) begin
          if (l2_req_if_aw[1:0] == 2'd3) begin
            addr_d  = l2_req_if_aw[LINE_ADDR_W+1:2];
            mesi_d  = l2_req_if_aw[1:0];
            beat_d  = '0;
            line_d  = '0;
            state_d = DATA;
          end else begin
            push          = 1'b1;
            push_rec.addr = l2_req_if_aw[LINE_ADDR_W+1:2];
            push_rec.mesi = l2_req_if_aw[1:0];
          end
        end
      end
      DATA: begin
        if (l2_req_if_wvalid) begin
          line_d[beat_q*BEAT_W +: BEAT_W] = l2_req_if_w;
          beat_d = beat_q + 1'b1;
          if (beat_q == BEAT_CNT_W'(BEATS - 1)) begin
            push           = 1'b1;
            push_rec.addr  = addr_q;
            push_rec.mesi  = mesi_q;
            push_rec.dirty = 1'b1;
            push_rec.data  = line_d;
            beat_d         = '0;
            state_d        = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // the pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      line_q      <= '0;
      addr_q      <= '0;
      mesi_q      <= '0;
      proto_err_q <= 1'b0;
      ready_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      line_q      <= line_d;
      addr_q      <= addr_d;
      mesi_q      <= mesi_d;
      proto_err_q <= proto_err_d;
      ready_q     <= 1'b1;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // NOTE: record storage is deliberately not reset; slots are only read while
  // count_q says they hold a pushed record, and the outputs are gated below.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_rec;
  end

  always_comb begin
    head_rec = '0;
    if (evict_vld_o) head_rec = mem_q[rd_ptr_q];
  end

  assign evict_line_addr_o = head_rec.addr;
  assign evict_mesi_o      = head_rec.mesi;
  assign evict_dirty_o     = head_rec.dirty;
  assign evict_data_o      = head_rec.data;

endmodule

// File: tb/tb_rvh_l2_ewrq_rx.sv
// Directed bench for rvh_l2_ewrq_rx: clean/dirty evictions, stalls,
// backpressure, protocol error and reset in the middle of a burst.
module tb_rvh_l2_ewrq_rx;

  logic         clk = 1'b0;
  logic         rst;
  logic         awvalid, awready, wvalid, wready;
  logic [15:0]  aw;
  logic [63:0]  w;
  logic         evict_vld, evict_rdy, evict_dirty, busy, proto_err;
  logic [13:0]  evict_addr;
  logic [1:0]   evict_mesi;
  logic [511:0] evict_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rvh_l2_ewrq_rx #(.OUT_DEPTH(2), .LINE_ADDR_W(14), .BEAT_W(64), .BEATS(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .l2_req_if_awvalid (awvalid),
    .l2_req_if_awready (awready),
    .l2_req_if_aw      (aw),
    .l2_req_if_wvalid  (wvalid),
    .l2_req_if_wready  (wready),
    .l2_req_if_w       (w),
    .evict_vld_o       (evict_vld),
    .evict_rdy_i       (evict_rdy),
    .evict_line_addr_o (evict_addr),
    .evict_mesi_o      (evict_mesi),
    .evict_dirty_o     (evict_dirty),
    .evict_data_o      (evict_data),
    .busy_o            (busy),
    .proto_err_o       (proto_err)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_send(input logic [15:0] a);
    bit done = 1'b0;
    awvalid = 1'b1;
    aw      = a;
    for (int i = 0; i < 20 && !done; i++) begin
      if (awready) done = 1'b1;
      tick();
    end
    if (!done) check("aw_timeout", 1'b0, 1'b1);
    awvalid = 1'b0;
  endtask

  function automatic logic [511:0] rep_line(input logic [7:0] base);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = {8{base + 8'(k)}};
    return l;
  endfunction

  task automatic check_rec(input string tag, input logic [13:0] a, input logic [1:0] m,
                           input logic d, input logic [511:0] data);
    check({tag, "_vld"},   evict_vld,   1'b1);
    check({tag, "_addr"},  evict_addr,  a);
    check({tag, "_mesi"},  evict_mesi,  m);
    check({tag, "_dirty"}, evict_dirty, d);
    check({tag, "_data"},  evict_data,  data);
  endtask

  task automatic pop_one();
    evict_rdy = 1'b1;
    tick();
    evict_rdy = 1'b0;
  endtask

  initial begin
    logic [511:0] exp_line;
    rst = 1'b0; awvalid = 1'b0; aw = '0; wvalid = 1'b0; w = '0; evict_rdy = 1'b0;

    // Reset: everything low, awready rises after release.
    #12;
    check("rst_awready", awready, 1'b0);
    check("rst_wready",  wready,  1'b0);
    check("rst_vld",     evict_vld, 1'b0);
    check("rst_busy",    busy, 1'b0);
    check("rst_perr",    proto_err, 1'b0);
    check("rst_data",    evict_data, '0);
    rst = 1'b1;
    tick();
    check("post_rst_awready", awready, 1'b1);

    // Clean eviction: record visible one cycle after the handshake.
    aw_send(16'h1235);
    check_rec("clean", 14'h048D, 2'd1, 1'b0, '0);
    check("clean_wready", wready, 1'b0);
    check("clean_busy",   busy, 1'b1);
    pop_one();
    check("clean_popped", evict_vld, 1'b0);
    check("clean_idle_busy", busy, 1'b0);

    // Dirty eviction, back-to-back beats.
    aw_send(16'hFFFF);
    check("dirty_wready",  wready, 1'b1);
    check("dirty_awready", awready, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) check("dirty_pre_last_vld", evict_vld, 1'b0);
      wvalid = 1'b1;
      w = {8{8'(k)}};
      tick();
    end
    wvalid = 1'b0;
    check_rec("dirty", 14'h3FFF, 2'd3, 1'b1, rep_line(8'h00));
    check("dirty_lo_beat", evict_data[63:0], 64'h0);
    check("dirty_hi_beat", evict_data[511:448], 64'h0707070707070707);
    check("dirty_awready_back", awready, 1'b1);
    check("dirty_wready_off",   wready, 1'b0);
    pop_one();

    // Stalled burst: gaps of 1..3 idle cycles between beats.
    aw_send({14'h0155, 2'd3});
    for (int k = 0; k < 8; k++) begin
      wvalid = 1'b0;
      for (int g = 0; g < (k % 3) + 1; g++) tick();
      check("stall_awready_low", awready, 1'b0);
      wvalid = 1'b1;
      w = {8{8'(k)}};
      tick();
    end
    wvalid = 1'b0;
    check_rec("stall", 14'h0155, 2'd3, 1'b1, rep_line(8'h00));
    check("stall_awready_back", awready, 1'b1);
    pop_one();

    // Backpressure with a two-entry queue.
    aw_send({14'h0011, 2'd0});
    aw_send({14'h0022, 2'd2});
    awvalid = 1'b1;
    aw = {14'h0033, 2'd1};
    for (int i = 0; i < 3; i++) begin
      check("bp_awready_full", awready, 1'b0);
      tick();
    end
    check_rec("bp_head_a", 14'h0011, 2'd0, 1'b0, '0);
    pop_one();
    check("bp_awready_reopen", awready, 1'b1);
    check_rec("bp_head_b", 14'h0022, 2'd2, 1'b0, '0);
    tick();
    awvalid = 1'b0;
    check_rec("bp_b_still", 14'h0022, 2'd2, 1'b0, '0);
    pop_one();
    check_rec("bp_head_c", 14'h0033, 2'd1, 1'b0, '0);
    pop_one();
    check("bp_drained", evict_vld, 1'b0);

    // Protocol error: stray W beat in IDLE.
    check("perr_before", proto_err, 1'b0);
    wvalid = 1'b1;
    w = 64'hDEAD_BEEF_0000_0001;
    tick();
    wvalid = 1'b0;
    check("perr_set",  proto_err, 1'b1);
    check("perr_vld",  evict_vld, 1'b0);
    check("perr_busy", busy, 1'b0);
    tick(); tick();
    check("perr_sticky", proto_err, 1'b1);

    // Reset after four beats of a dirty burst.
    aw_send({14'h2AAA, 2'd3});
    for (int k = 0; k < 4; k++) begin
      wvalid = 1'b1;
      w = {8{8'hF0 + 8'(k)}};
      tick();
    end
    wvalid = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_rst_awready", awready, 1'b0);
    check("mid_rst_wready",  wready, 1'b0);
    check("mid_rst_vld",     evict_vld, 1'b0);
    check("mid_rst_busy",    busy, 1'b0);
    check("mid_rst_perr",    proto_err, 1'b0);
    check("mid_rst_data",    evict_data, '0);
    rst = 1'b1;
    tick();
    aw_send({14'h1234, 2'd3});
    for (int k = 0; k < 8; k++) begin
      wvalid = 1'b1;
      w = {8{8'hA0 + 8'(k)}};
      tick();
    end
    wvalid = 1'b0;
    exp_line = rep_line(8'hA0);
    check_rec("after_rst", 14'h1234, 2'd3, 1'b1, exp_line);
    pop_one();
    check("final_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rvh_l2_ewrq_rx.md
# rvh_l2_ewrq_rx

Responder end of the L1D eviction write channel, sitting at the L2 bank input. Accepts eviction address requests (AW) and, for dirty lines, the following 8-beat 64-bit write burst (W). Assembles each eviction into one 512-bit line record and queues it toward the L2 bank writeback port. Clean evictions carry no data and are forwarded as address/state-only records.

## Interface
- OUT_DEPTH, 2, entries in the output record queue (≥1)
- LINE_ADDR_W, 14, line address width
- BEAT_W, 64, W beat width
- BEATS, 8, beats per dirty line (line = BEATS*BEAT_W = 512 bits)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- l2_req_if_awvalid  in  1  AW request valid
- l2_req_if_awready  out  1  AW accept
- l2_req_if_aw  in  16  [15:2] line address, [1:0] MESI state of evicted line
- l2_req_if_wvalid  in  1  W beat valid
- l2_req_if_wready  out  1  W accept
- l2_req_if_w  in  64  W beat data
- evict_vld_o  out  1  output record valid
- evict_rdy_i  in  1  L2 bank accepts record
- evict_line_addr_o  out  14  record line address
- evict_mesi_o  out  2  record MESI state
- evict_dirty_o  out  1  record carries data
- evict_data_o  out  512  record line data (0 when clean)
- busy_o  out  1  burst in progress or queue non-empty
- proto_err_o  out  1  sticky: W beat seen outside a burst

## Operation
- FSM states: IDLE, DATA.
- Reservation count = queue occupancy + (state==DATA). awready = (state==IDLE) & (reservation < OUT_DEPTH); computed from registered state only, no combinational path from evict_rdy_i.
- AW handshake in IDLE, mesi==2'd3 (Modified): latch addr/mesi, clear beat counter, go DATA.
- AW handshake in IDLE, mesi!=3: push record {addr, mesi, dirty=0, data=0} into queue same edge; stay IDLE.
- DATA: wready=1. Each cycle with wvalid, beat k written to line bits [64k+63:64k], beat 0 first; counter (3 bits) increments. Cycles without wvalid are stalls, no effect. On beat 7 accepted: push {addr, mesi, dirty=1, line}, counter wraps to 0, go IDLE.
- Pushes never block: space was reserved at AW acceptance.
- IDLE: wready=0; wvalid=1 sets proto_err_o (cleared only by reset); beat dropped.
- Queue: FIFO, head drives evict_* outputs; pop on evict_vld_o & evict_rdy_i. Push and pop in the same cycle both take effect.
- busy_o = (state==DATA) | queue non-empty.

## Timing
- Reset (rst=0, asynchronous): state IDLE, counter 0, queue empty, proto_err_o 0; all outputs 0 including awready and wready. awready rises in the first cycle after reset release.
- Clean eviction: AW handshake at edge N → evict_vld_o high after edge N (cycle N+1) with queue previously empty.
- Dirty eviction: AW handshake edge N; wready high from cycle N+1; with back-to-back beats, last beat at edge N+8 → evict_vld_o cycle N+9; awready high again in cycle N+9 if reservation allows.
- Initiator drives 8 consecutive beats without sampling wready; receiver meets this by holding wready=1 throughout DATA.
- Queue full (OUT_DEPTH records): awready=0 until a pop retires; earliest re-accept is the cycle after the pop edge.
- Reset mid-burst: partial line and queue contents discarded; no record emitted.

## Test plan
- Clean: AW 0x1235 (line 0x048D, mesi 1) → one cycle later evict_vld_o=1, line_addr 0x048D, mesi 1, dirty 0, data 0; wready stays 0.
- Dirty back-to-back: AW 0xFFFF (line 0x3FFF, mesi 3), beats 0x00..07 replicated per byte → record dirty=1, data[63:0]=0x0000…00, data[511:448]=0x0707…07, evict_vld_o exactly 1 cycle after beat 7.
- Stalled burst: beats with wvalid gaps of 1–3 cycles → identical 512-bit data; awready stays 0 until after beat 7.
- Backpressure: evict_rdy_i=0, OUT_DEPTH=2, three clean AWs → first two accepted, awready=0 for the third until evict_rdy_i=1 for one cycle; records emerge in order.
- Protocol error: wvalid=1 in IDLE → proto_err_o=1 sticky, no record, queue unchanged.
- Reset after 4 beats of a dirty burst → all outputs 0, busy_o 0, next dirty burst captured cleanly.
